uart_rx: RTL and testbench

UART receiver. It is the receive-side counterpart of the uart_tx block and shares its BIT_RATE/CLK_HZ/PAYLOAD_BITS/STOP_BITS parameter set and bit-period arithmetic. It samples the asynchronous uart_rxd pin at mid-bit, assembles an LSB-first payload, checks the stop bit(s), and presents each good word with a single-cycle valid strobe. It also reports framing errors and line breaks.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the bit-period arithmetic
// common to the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RECV  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } rx_state_t;

    // Integer-ns periods are divided, so the tx and rx sides round identically.
    function automatic int unsigned cycles_per_bit(input int unsigned bit_rate,
                                                   input int unsigned clk_hz);
        int unsigned bit_p;
        int unsigned clk_p;
        bit_p = 32'd1_000_000_000 / bit_rate;
        clk_p = 32'd1_000_000_000 / clk_hz;
        return bit_p / clk_p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous receive pin, with a one-cycle
// delayed copy used to detect the falling edge of a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic meta_r;
    logic rxd_r;
    logic prev_r;

    // Synchronizer chain; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b1;
            rxd_r  <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= rxd;
            rxd_r  <= meta_r;
            prev_r <= rxd_r;
        end
    end

    assign rxd_s = rxd_r;
    assign fall  = prev_r & ~rxd_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of an LSB-first frame with stop-bit checking,
// reporting good words, framing errors and line breaks as one-cycle strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 115200,
    parameter int CLK_HZ       = 100_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int unsigned CPB  = cycles_per_bit(BIT_RATE, CLK_HZ);
    localparam int unsigned HALF = CPB / 2;
    localparam int          CNT_W = 1 + $clog2(CPB);

    localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CPB_M1    = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    logic                    rxd_s;
    logic                    fall_s;
    logic                    stop_err_s;
    logic [PAYLOAD_BITS:0]   shift_ext_s;

    rx_state_t               state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [3:0]              bit_idx_r;
    logic [PAYLOAD_BITS-1:0] shift_r;
    logic                    err_r;
    logic                    valid_r;
    logic [PAYLOAD_BITS-1:0] data_r;
    logic                    ferr_r;
    logic                    brk_r;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rxd   (uart_rxd),
        .rxd_s (rxd_s),
        .fall  (fall_s)
    );

    // The new bit enters at the MSB; this form also holds for 1-bit payloads.
    assign shift_ext_s = {rxd_s, shift_r};
    assign stop_err_s  = err_r | ~rxd_s;

    // Frame FSM; strobes are set on the transition into DONE so they are visible there only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            bit_idx_r <= 4'd0;
            shift_r   <= {PAYLOAD_BITS{1'b0}};
            err_r     <= 1'b0;
            valid_r   <= 1'b0;
            data_r    <= {PAYLOAD_BITS{1'b0}};
            ferr_r    <= 1'b0;
            brk_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            brk_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Edge-triggered start so a held-low break cannot retrigger.
                    if (fall_s && uart_rx_en) begin
                        state_r <= START;
                        cnt_r   <= {CNT_W{1'b0}};
                        err_r   <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (cnt_r == HALF_C) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        bit_idx_r <= 4'd0;
                        state_r   <= rxd_s ? IDLE : RECV;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RECV: begin
                    if (cnt_r == CPB_M1) begin
                        shift_r <= shift_ext_s[PAYLOAD_BITS:1];
                        cnt_r   <= {CNT_W{1'b0}};
                        if (bit_idx_r == LAST_DATA) begin
                            bit_idx_r <= 4'd0;
                            state_r   <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == CPB_M1) begin
                        cnt_r <= {CNT_W{1'b0}};
                        err_r <= stop_err_s;
                        if (bit_idx_r == LAST_STOP) begin
                            bit_idx_r <= 4'd0;
                            state_r   <= DONE;
                            if (!stop_err_s) begin
                                valid_r <= 1'b1;
                                data_r  <= shift_r;
                            end else if (shift_r == {PAYLOAD_BITS{1'b0}}) begin
                                brk_r <= 1'b1;
                            end else begin
                                ferr_r <= 1'b1;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign uart_rx_valid     = valid_r;
    assign uart_rx_data      = data_r;
    assign uart_rx_frame_err = ferr_r;
    assign uart_rx_break     = brk_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 Mbit/s on a 100 MHz clock (CPB=100, 8N1):
// directed scenarios plus randomized frames against an event-level frame model.
module tb_uart_rx;

    localparam int CPB = 100;
    localparam int PB  = 8;

    typedef struct {
        int kind;   // 1 = valid, 2 = framing error, 3 = break
        int data;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;
    logic       uart_rx_break;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         viol = 0;
    int         fall_cyc = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] prev_data = 8'h00;
    ev_t        obs_q[$];
    ev_t        exp_q[$];
    ev_t        last_obs[$];

    uart_rx #(
        .BIT_RATE     (1_000_000),
        .CLK_HZ       (100_000_000),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_break     (uart_rx_break)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes and watch the one-strobe / data-only-on-valid invariants.
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            prev_data = uart_rx_data;
        end else begin
            if (int'(uart_rx_valid) + int'(uart_rx_frame_err) + int'(uart_rx_break) > 1) viol++;
            if (uart_rx_data !== prev_data && uart_rx_valid !== 1'b1) viol++;
            e.data = int'(uart_rx_data);
            e.cyc  = cyc;
            if (uart_rx_valid)     begin e.kind = 1; obs_q.push_back(e); end
            if (uart_rx_frame_err) begin e.kind = 2; obs_q.push_back(e); end
            if (uart_rx_break)     begin e.kind = 3; obs_q.push_back(e); end
            prev_data = uart_rx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_level(input logic v, input int ncyc);
        uart_rxd = v;
        repeat (ncyc) @(negedge clk);
    endtask

    // Frame-level model: outcome follows from enable, stop bit and payload alone.
    task automatic expect_frame(input logic [7:0] b, input logic stop_ok);
        ev_t e;
        if (uart_rx_en) begin
            e.cyc = 0;
            if (stop_ok) begin
                e.kind = 1;
                last_good = b;
            end else begin
                e.kind = (b == 8'h00) ? 3 : 2;
            end
            e.data = int'(last_good);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        expect_frame(b, stop_ok);
        fall_cyc = cyc;
        drive_level(1'b0, CPB);
        for (int i = 0; i < PB; i++) drive_level(b[i], CPB);
        drive_level(stop_ok, CPB);
    endtask

    task automatic compare(input string tag);
        drive_level(1'b1, 3 * CPB);
        check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_kind%0d", tag, i), obs_q[i].kind, exp_q[i].kind);
            check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
        end
        check($sformatf("%s_held", tag), {24'd0, uart_rx_data}, {24'd0, last_good});
        last_obs = obs_q;
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int lat;
        int gap;
        logic [7:0] b;
        logic ok;

        reset = 1'b1;
        uart_rxd = 1'b1;
        uart_rx_en = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_valid", uart_rx_valid, 1'b0);
        check("rst_data", uart_rx_data, 8'h00);
        check("rst_ferr", uart_rx_frame_err, 1'b0);
        check("rst_brk", uart_rx_break, 1'b0);
        reset = 1'b0;
        drive_level(1'b1, 2 * CPB);

        // Single frame with latency from the pin's falling edge.
        send_frame(8'hA5, 1'b1);
        compare("a5");
        lat = (last_obs.size() > 0) ? last_obs[0].cyc - fall_cyc : -1;
        check("a5_latency_in_window", (lat >= 952 && lat <= 955), 1'b1);

        // Zero-gap frames land exactly one frame time apart.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        compare("b2b");
        gap = (last_obs.size() >= 2) ? last_obs[1].cyc - last_obs[0].cyc : -1;
        check("b2b_gap", gap, 1000);

        // Short low glitch is rejected at mid start bit.
        drive_level(1'b0, 20);
        drive_level(1'b1, 2 * CPB);
        compare("glitch");
        send_frame(8'h3C, 1'b1);
        compare("after_glitch");

        // Bad stop bit with non-zero payload.
        send_frame(8'h11, 1'b1);
        send_frame(8'h5A, 1'b0);
        compare("frame_err");

        // Line break: one strobe, no retrigger while held low.
        begin
            ev_t e;
            e.kind = 3; e.data = int'(last_good); e.cyc = 0;
            exp_q.push_back(e);
        end
        drive_level(1'b0, 15 * CPB);
        drive_level(1'b1, 2 * CPB);
        send_frame(8'h81, 1'b1);
        compare("break");

        // Reset in the middle of data bit 3 aborts the frame.
        drive_level(1'b0, CPB);
        drive_level(1'b1, CPB);
        drive_level(1'b1, CPB);
        drive_level(1'b0, CPB);
        drive_level(1'b0, CPB / 2);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", uart_rx_valid, 1'b0);
        check("mid_rst_data", uart_rx_data, 8'h00);
        check("mid_rst_ferr", uart_rx_frame_err, 1'b0);
        check("mid_rst_brk", uart_rx_break, 1'b0);
        last_good = 8'h00;
        @(negedge clk);
        drive_level(1'b1, 10);
        reset = 1'b0;
        compare("reset_abort");
        send_frame(8'h7E, 1'b1);
        compare("after_reset");

        // Enable gates start detection.
        uart_rx_en = 1'b0;
        send_frame(8'h42, 1'b1);
        compare("disabled");
        uart_rx_en = 1'b1;
        send_frame(8'h24, 1'b1);
        compare("enabled");

        // Randomized frames, stop errors, enable and idle gaps.
        for (int n = 0; n < 20; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            uart_rx_en = ($urandom_range(0, 7) != 0);
            send_frame(b, ok);
            gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
            drive_level(1'b1, gap * CPB);
        end
        uart_rx_en = 1'b1;
        compare("random");

        check("invariants", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
